// File: rtl/hazard_sequencer.sv
// Stall/flush controller for the 5-stage pipeline: fixed-priority hazard resolution,
// deferred redirect behind i-cache misses, drain/halt sequencing and saturating counters.
module hazard_sequencer #(
  parameter int ADDR_W       = 32,
  parameter int CNT_W        = 32,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ic_miss,
  input  logic              dc_miss,
  input  logic              dec_uses_rs,
  input  logic [4:0]        dec_rs_addr,
  input  logic              dec_uses_rt,
  input  logic [4:0]        dec_rt_addr,
  input  logic              ex_is_load,
  input  logic [4:0]        ex_rw_addr,
  input  logic              ex_mispredict,
  input  logic [ADDR_W-1:0] ex_recovery_target,
  input  logic              drain_req,
  output logic              pc_stall,
  output logic              pc_redirect,
  output logic [ADDR_W-1:0] pc_redirect_target,
  output logic              i2d_stall,
  output logic              i2d_flush,
  output logic              d2e_stall,
  output logic              d2e_flush,
  output logic              e2m_stall,
  output logic              e2m_flush,
  output logic              m2w_stall,
  output logic              m2w_flush,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  mispredict_count
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam int DC_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DC_W-1:0] DRAIN_LOAD = DC_W'(DRAIN_CYCLES);
  localparam logic [DC_W-1:0] DRAIN_ONE  = DC_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_t            state_r;
  state_t            state_nxt_s;
  logic [DC_W-1:0]   drain_cnt_r;
  logic [DC_W-1:0]   drain_cnt_nxt_s;
  logic              pend_r;
  logic [ADDR_W-1:0] pend_tgt_r;
  logic [CNT_W-1:0]  stall_cnt_r;
  logic [CNT_W-1:0]  mp_cnt_r;

  logic lu_s;
  logic mp_accept_s;
  logic mp_defer_s;
  logic pend_fire_s;

  assign lu_s = ex_is_load & (ex_rw_addr != 5'd0) &
                ((dec_uses_rs & (dec_rs_addr == ex_rw_addr)) |
                 (dec_uses_rt & (dec_rt_addr == ex_rw_addr)));

  // A d-cache miss freezes EX, so the branch re-presents its mispredict next cycle.
  assign mp_accept_s = ex_mispredict & ~dc_miss;
  assign mp_defer_s  = mp_accept_s & (ic_miss | (state_r != RUN));
  assign pend_fire_s = pend_r & ~mp_accept_s & ~dc_miss & ~ic_miss & ~lu_s & (state_r == RUN);

  assign halted           = (state_r == HALTED);
  assign stall_cycles     = stall_cnt_r;
  assign mispredict_count = mp_cnt_r;

  // Per-cycle pipeline controls in priority order.
  always_comb begin
    pc_stall           = 1'b0;
    pc_redirect        = 1'b0;
    pc_redirect_target = {ADDR_W{1'b0}};
    i2d_stall          = 1'b0;
    i2d_flush          = 1'b0;
    d2e_stall          = 1'b0;
    d2e_flush          = 1'b0;
    e2m_stall          = 1'b0;
    e2m_flush          = 1'b0;
    m2w_stall          = 1'b0;
    m2w_flush          = 1'b0;
    if (dc_miss) begin
      pc_stall  = 1'b1;
      i2d_stall = 1'b1;
      d2e_stall = 1'b1;
      e2m_stall = 1'b1;
      m2w_flush = 1'b1;
    end else if (mp_accept_s) begin
      i2d_flush = 1'b1;
      d2e_flush = 1'b1;
      if (mp_defer_s) begin
        pc_stall = 1'b1;
      end else begin
        pc_redirect        = 1'b1;
        pc_redirect_target = ex_recovery_target;
      end
    end else if (lu_s) begin
      pc_stall  = 1'b1;
      i2d_stall = 1'b1;
      d2e_flush = 1'b1;
    end else if (pend_fire_s) begin
      pc_redirect        = 1'b1;
      pc_redirect_target = pend_tgt_r;
      i2d_flush          = 1'b1;
    end else if (ic_miss | pend_r | (state_r != RUN)) begin
      // Fetch is frozen; whatever sits in i2d is wrong-path or a bubble.
      pc_stall  = 1'b1;
      i2d_flush = 1'b1;
    end else begin
      pc_stall  = 1'b0;
      i2d_flush = 1'b0;
    end
  end

  // Drain/halt next-state and drain counter.
  always_comb begin
    state_nxt_s     = state_r;
    drain_cnt_nxt_s = drain_cnt_r;
    case (state_r)
      RUN: begin
        if (drain_req) begin
          state_nxt_s     = DRAIN;
          drain_cnt_nxt_s = DRAIN_LOAD;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DRAIN: begin
        if (!drain_req) begin
          state_nxt_s = RUN;
        end else if (!e2m_stall) begin
          drain_cnt_nxt_s = drain_cnt_r - DRAIN_ONE;
          if (drain_cnt_r == DRAIN_ONE) begin
            state_nxt_s = HALTED;
          end else begin
            state_nxt_s = DRAIN;
          end
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      HALTED: begin
        if (!drain_req) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = HALTED;
        end
      end
      default: begin
        state_nxt_s     = RUN;
        drain_cnt_nxt_s = {DC_W{1'b0}};
      end
    endcase
  end

  // State, pending redirect and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= RUN;
      drain_cnt_r <= {DC_W{1'b0}};
      pend_r      <= 1'b0;
      pend_tgt_r  <= {ADDR_W{1'b0}};
      stall_cnt_r <= {CNT_W{1'b0}};
      mp_cnt_r    <= {CNT_W{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      drain_cnt_r <= drain_cnt_nxt_s;
      if (mp_defer_s) begin
        pend_r     <= 1'b1;
        pend_tgt_r <= ex_recovery_target;
      end else if (mp_accept_s | pend_fire_s) begin
        pend_r <= 1'b0;
      end
      if ((state_r == RUN) && pc_stall && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (mp_accept_s && (mp_cnt_r != CNT_MAX)) begin
        mp_cnt_r <= mp_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer: expected control vectors queued per step and
// compared when the cycle's outputs settle; counters tracked by a small saturating model.
module tb_hazard_sequencer;

  localparam logic [10:0] K_PS = 11'h400;
  localparam logic [10:0] K_PR = 11'h200;
  localparam logic [10:0] K_IS = 11'h100;
  localparam logic [10:0] K_IF = 11'h080;
  localparam logic [10:0] K_DS = 11'h040;
  localparam logic [10:0] K_DF = 11'h020;
  localparam logic [10:0] K_ES = 11'h010;
  localparam logic [10:0] K_EF = 11'h008;
  localparam logic [10:0] K_MS = 11'h004;
  localparam logic [10:0] K_MF = 11'h002;
  localparam logic [10:0] K_HT = 11'h001;
  localparam logic [10:0] K_NONE = 11'h000;
  localparam logic [10:0] K_DC = K_PS | K_IS | K_DS | K_ES | K_MF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ic_miss, dc_miss;
  logic        dec_uses_rs, dec_uses_rt;
  logic [4:0]  dec_rs_addr, dec_rt_addr;
  logic        ex_is_load;
  logic [4:0]  ex_rw_addr;
  logic        ex_mispredict;
  logic [31:0] ex_recovery_target;
  logic        drain_req;
  logic        pc_stall, pc_redirect;
  logic [31:0] pc_redirect_target;
  logic        i2d_stall, i2d_flush, d2e_stall, d2e_flush;
  logic        e2m_stall, e2m_flush, m2w_stall, m2w_flush;
  logic        halted;
  logic [3:0]  stall_cycles, mispredict_count;

  int vectors = 0;
  int miscompares = 0;
  int run_state = 1;
  logic [3:0] exp_stall = 4'd0;
  logic [3:0] exp_mp = 4'd0;

  string       tag_q[$];
  logic [42:0] exp_q[$];

  hazard_sequencer #(.ADDR_W(32), .CNT_W(4), .DRAIN_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .ic_miss(ic_miss), .dc_miss(dc_miss),
    .dec_uses_rs(dec_uses_rs), .dec_rs_addr(dec_rs_addr),
    .dec_uses_rt(dec_uses_rt), .dec_rt_addr(dec_rt_addr),
    .ex_is_load(ex_is_load), .ex_rw_addr(ex_rw_addr),
    .ex_mispredict(ex_mispredict), .ex_recovery_target(ex_recovery_target),
    .drain_req(drain_req), .pc_stall(pc_stall), .pc_redirect(pc_redirect),
    .pc_redirect_target(pc_redirect_target),
    .i2d_stall(i2d_stall), .i2d_flush(i2d_flush), .d2e_stall(d2e_stall), .d2e_flush(d2e_flush),
    .e2m_stall(e2m_stall), .e2m_flush(e2m_flush), .m2w_stall(m2w_stall), .m2w_flush(m2w_flush),
    .halted(halted), .stall_cycles(stall_cycles), .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  task automatic idle();
    ic_miss = 1'b0; dc_miss = 1'b0;
    dec_uses_rs = 1'b0; dec_rs_addr = 5'd0; dec_uses_rt = 1'b0; dec_rt_addr = 5'd0;
    ex_is_load = 1'b0; ex_rw_addr = 5'd0;
    ex_mispredict = 1'b0; ex_recovery_target = 32'd0;
    drain_req = 1'b0;
  endtask

  function automatic logic [10:0] observed();
    return {pc_stall, pc_redirect, i2d_stall, i2d_flush, d2e_stall, d2e_flush,
            e2m_stall, e2m_flush, m2w_stall, m2w_flush, halted};
  endfunction

  // Inputs are already driven; queue the expectation, compare once settled, then clock.
  task automatic step(input string tag, input logic [10:0] ctl, input logic [31:0] tgt);
    string       t;
    logic [42:0] e;
    logic [10:0] obs;
    tag_q.push_back(tag);
    exp_q.push_back({ctl, tgt});
    #3;
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    obs = observed();
    vectors++;
    assert (obs === e[42:32]) else begin
      miscompares++;
      $error("FAIL %s ctl observed=%b expected=%b", t, obs, e[42:32]);
    end
    if (e[41]) begin
      vectors++;
      assert (pc_redirect_target === e[31:0]) else begin
        miscompares++;
        $error("FAIL %s target observed=%h expected=%h", t, pc_redirect_target, e[31:0]);
      end
    end
    if ((run_state != 0) && (ctl[10] == 1'b1) && (exp_stall != 4'hF)) exp_stall = exp_stall + 4'd1;
    @(posedge clk);
    #2;
  endtask

  task automatic chk_cnt(input string tag);
    vectors++;
    assert (stall_cycles === exp_stall) else begin
      miscompares++;
      $error("FAIL %s stall_cycles observed=%0d expected=%0d", tag, stall_cycles, exp_stall);
    end
    vectors++;
    assert (mispredict_count === exp_mp) else begin
      miscompares++;
      $error("FAIL %s mispredict_count observed=%0d expected=%0d", tag, mispredict_count, exp_mp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    #3;
    vectors++;
    assert (observed() === K_NONE) else begin
      miscompares++;
      $error("FAIL reset ctl observed=%b expected=%b", observed(), K_NONE);
    end
    chk_cnt("reset");
    #4 rst_n = 1'b1;
    @(posedge clk);
    #2;

    // Load-use detection
    ex_is_load = 1'b1; ex_rw_addr = 5'd5; dec_uses_rs = 1'b1; dec_rs_addr = 5'd5;
    step("lu_rs", K_PS | K_IS | K_DF, 32'd0);
    ex_rw_addr = 5'd0; dec_rs_addr = 5'd0;
    step("lu_r0", K_NONE, 32'd0);
    dec_uses_rs = 1'b0; dec_uses_rt = 1'b1; dec_rt_addr = 5'd7; ex_rw_addr = 5'd7;
    step("lu_rt", K_PS | K_IS | K_DF, 32'd0);
    ic_miss = 1'b1;
    step("lu_icmiss", K_PS | K_IS | K_DF, 32'd0);
    idle();
    step("idle", K_NONE, 32'd0);

    // Mispredict held behind a d-cache miss
    dc_miss = 1'b1; ex_mispredict = 1'b1; ex_recovery_target = 32'h100;
    for (int i = 0; i < 3; i++) step("dc_hold", K_DC, 32'd0);
    chk_cnt("dc_hold_cnt");
    dc_miss = 1'b0;
    step("dc_release", K_PR | K_IF | K_DF, 32'h100);
    exp_mp = 4'd1;
    idle();
    chk_cnt("dc_mp_cnt");

    // Mispredict deferred behind an i-cache miss
    ic_miss = 1'b1; ex_mispredict = 1'b1; ex_recovery_target = 32'h400;
    step("ic_mp", K_PS | K_IF | K_DF, 32'd0);
    exp_mp = 4'd2;
    ex_mispredict = 1'b0; ex_recovery_target = 32'd0;
    for (int i = 0; i < 3; i++) step("ic_pend", K_PS | K_IF, 32'd0);
    ic_miss = 1'b0;
    step("ic_fire", K_PR | K_IF, 32'h400);
    step("ic_after", K_NONE, 32'd0);

    // Newest deferred mispredict wins
    ic_miss = 1'b1; ex_mispredict = 1'b1; ex_recovery_target = 32'h500;
    step("new_mp1", K_PS | K_IF | K_DF, 32'd0);
    ex_recovery_target = 32'h600;
    step("new_mp2", K_PS | K_IF | K_DF, 32'd0);
    exp_mp = 4'd4;
    idle();
    step("new_fire", K_PR | K_IF, 32'h600);
    chk_cnt("mid_cnt");

    // Drain to halt with one d-cache miss inside DRAIN
    drain_req = 1'b1;
    step("drain_enter", K_NONE, 32'd0);
    run_state = 0;
    dc_miss = 1'b1;
    step("drain_dc", K_DC, 32'd0);
    dc_miss = 1'b0;
    for (int i = 0; i < 4; i++) step("drain_adv", K_PS | K_IF, 32'd0);
    step("halted", K_PS | K_IF | K_HT, 32'd0);
    drain_req = 1'b0;
    step("halt_exit", K_PS | K_IF | K_HT, 32'd0);
    run_state = 1;
    step("run_again", K_NONE, 32'd0);

    // Drain aborted after two cycles
    drain_req = 1'b1;
    step("abort_enter", K_NONE, 32'd0);
    run_state = 0;
    step("abort_d1", K_PS | K_IF, 32'd0);
    step("abort_d2", K_PS | K_IF, 32'd0);
    drain_req = 1'b0;
    step("abort_drop", K_PS | K_IF, 32'd0);
    run_state = 1;
    step("abort_run", K_NONE, 32'd0);

    // Reset in the middle of DRAIN with a redirect pending
    drain_req = 1'b1;
    step("rst_enter", K_NONE, 32'd0);
    run_state = 0;
    ex_mispredict = 1'b1; ex_recovery_target = 32'h700;
    step("rst_mp", K_PS | K_IF | K_DF, 32'd0);
    exp_mp = 4'd5;
    ex_mispredict = 1'b0; ex_recovery_target = 32'd0;
    step("rst_pend", K_PS | K_IF, 32'd0);
    chk_cnt("pre_rst_cnt");
    rst_n = 1'b0;
    drain_req = 1'b0;
    #1;
    exp_stall = 4'd0; exp_mp = 4'd0; run_state = 1;
    vectors++;
    assert (observed() === K_NONE) else begin
      miscompares++;
      $error("FAIL mid_rst ctl observed=%b expected=%b", observed(), K_NONE);
    end
    chk_cnt("mid_rst_cnt");
    rst_n = 1'b1;
    step("post_rst1", K_NONE, 32'd0);
    step("post_rst2", K_NONE, 32'd0);

    // Stall counter saturation
    ic_miss = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step("sat", K_PS | K_IF, 32'd0);
      if (i == 13) chk_cnt("sat_14");
    end
    idle();
    chk_cnt("sat_15");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
Central stall/flush controller for the 5-stage MIPS core. It drives the stall and flush controls of the four pipeline registers (i2d, d2e, e2m, m2w) and the fetch PC hold/redirect. It resolves d-cache miss, i-cache miss, load-use and branch-mispredict hazards with a fixed priority. It holds a pending redirect that is deferred behind an i-cache miss, runs a drain/halt FSM for external quiesce requests, and keeps saturating performance counters.

Parameters:
ADDR_W, 32, width of PC / redirect target
CNT_W, 32, width of each performance counter
DRAIN_CYCLES, 4, advancing (non-stalled) cycles needed to empty D/E/M/W after fetch stops

Ports:
clk  in  1  clock
rst_n  in  1  async reset, active low
ic_miss  in  1  i-cache cannot deliver instruction this cycle
dc_miss  in  1  d-cache access in MEM not complete this cycle
dec_uses_rs  in  1  decode instruction reads rs
dec_rs_addr  in  5  decode rs index
dec_uses_rt  in  1  decode instruction reads rt
dec_rt_addr  in  5  decode rt index
ex_is_load  in  1  EX instruction is a memory read writing rw
ex_rw_addr  in  5  EX destination register
ex_mispredict  in  1  EX branch resolved opposite to prediction
ex_recovery_target  in  ADDR_W  correct PC for mispredicted branch
drain_req  in  1  external quiesce request (level)
pc_stall  out  1  hold fetch PC
pc_redirect  out  1  load fetch PC with pc_redirect_target
pc_redirect_target  out  ADDR_W  redirect PC
i2d_stall, i2d_flush, d2e_stall, d2e_flush, e2m_stall, e2m_flush, m2w_stall, m2w_flush  out  1 each  per-register hazard controls
halted  out  1  pipeline drained, fetch frozen
stall_cycles  out  CNT_W  count of RUN-state cycles with pc_stall=1
mispredict_count  out  CNT_W  count of accepted mispredicts

Behaviour:
- Reset (async, rst_n=0): state=RUN, pend=0, pend_target=0, drain counter=0, both counters=0, halted=0. All control outputs are combinational and read 0 with all inputs idle. m2w_stall is always 0.
- lu = ex_is_load & (ex_rw_addr!=0) & ((dec_uses_rs & dec_rs_addr==ex_rw_addr) | (dec_uses_rt & dec_rt_addr==ex_rw_addr)).
- Priority, evaluated combinationally each cycle:
  1. dc_miss: pc_stall, i2d_stall, d2e_stall, e2m_stall=1; m2w_flush=1; all other controls 0. Mispredict and lu are ignored because the branch stays in EX and re-asserts next cycle.
  2. ex_mispredict (accepted): i2d_flush=d2e_flush=1; lu ignored. If ic_miss=1 or state!=RUN: pend<=1, pend_target<=ex_recovery_target, pc_stall=1, pc_redirect=0. Otherwise pc_redirect=1 with target=ex_recovery_target. mispredict_count increments.
  3. lu: pc_stall=1, i2d_stall=1, d2e_flush=1.
  4. ic_miss: pc_stall=1; i2d_flush=1 unless i2d_stall=1 (stall wins; flush forced 0).
- Pending redirect:
  - While pend=1, i2d_flush=1 (when not stalled) and pc_stall=1.
  - In the first cycle with pend=1, ic_miss=0, dc_miss=0 and state==RUN: pc_redirect=1, target=pend_target, pend clears at the next edge.
  - A newer accepted mispredict overwrites pend_target (newest wins).
- Drain FSM (RUN, DRAIN, HALTED):
  - RUN→DRAIN when drain_req=1. Counter is loaded with DRAIN_CYCLES.
  - DRAIN: pc_stall=1; i2d_flush=1 unless i2d_stall. The counter decrements on each cycle with e2m_stall=0. At counter==1 with e2m_stall=0, go to HALTED. drain_req=0 aborts to RUN on the next edge.
  - HALTED: halted=1, pc_stall=1, i2d_flush=1. Go to RUN on the edge after drain_req=0.
  - A reset mid-drain returns to RUN immediately.
- Counters: saturate at all-ones and never wrap. stall_cycles counts only in RUN.
- Timing: all controls are valid within the same cycle as their causes, so they act at the next clk edge. There is no added latency.

Test Plan:
- lu detect: ex_is_load=1, ex_rw_addr=5, dec_uses_rs=1, dec_rs_addr=5 → pc_stall=i2d_stall=d2e_flush=1, i2d_flush=0. Same stimulus with ex_rw_addr=0 → all controls 0.
- dc_miss held 3 cycles while ex_mispredict=1 (target 0x100) → 3 cycles of pc/i2d/d2e/e2m_stall=1 and m2w_flush=1 with no redirect. Cycle 4: pc_redirect=1, target 0x100, i2d_flush=d2e_flush=1. mispredict_count=1.
- ex_mispredict (target 0x400) during a 4-cycle ic_miss → pc_redirect=0 and i2d_flush=1 throughout. On the first cycle with ic_miss=0: pc_redirect=1, target 0x400, for exactly one cycle.
- drain_req=1 with one dc_miss cycle inside DRAIN → halted=1 after 5 cycles, with pc_stall high throughout. Drop drain_req → RUN and halted=0 after one edge. drain_req dropped after 2 cycles → aborts to RUN.
- CNT_W=4, pc_stall held 20 cycles in RUN → stall_cycles=15 (saturated).
- Assert rst_n=0 mid-DRAIN with pend=1 → halted=0, pend cleared, counters=0, no pc_redirect after release.
